gray_step_monitor: RTL and testbench

//   Downstream consumer of a Gray-coded position stream, e.g. a binary_to_gray stage or an encoder.

---
 rtl/gray_pkg.sv | 28 ++
 rtl/gray_to_binary.sv | 18 +
 rtl/gray_step_monitor.sv | 92 +++++++++
 tb/tb_gray_step_monitor.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/gray_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | gray_pkg : shared state encoding and Gray-to-binary helper           |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package gray_pkg;

  localparam int GRAY_MAX_W = 32;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_TRACK = 1'b1
  } state_t;

  // Zero-extended input decodes to a zero-extended result, so one fixed-width
  // prefix-XOR serves every WIDTH up to GRAY_MAX_W.
  function automatic logic [GRAY_MAX_W-1:0] gray2bin(input logic [GRAY_MAX_W-1:0] g);
    logic [GRAY_MAX_W-1:0] b;
    b = '0;
    b[GRAY_MAX_W-1] = g[GRAY_MAX_W-1];
    for (int i = GRAY_MAX_W-2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/gray_to_binary.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | gray_to_binary : combinational WIDTH-bit Gray decoder                |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module gray_to_binary
  import gray_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] gray,
  output logic [WIDTH-1:0] bin
);

  assign bin = WIDTH'(gray2bin(GRAY_MAX_W'(gray)));

endmodule
`default_nettype wire

// File: rtl/gray_step_monitor.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | gray_step_monitor : decodes a Gray position stream and classifies    |
// | each move as up / down / unchanged / illegal; counts illegal jumps.  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module gray_step_monitor
  import gray_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter int ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 g_valid,
  input  logic [WIDTH-1:0]     g_in,
  input  logic                 clear,
  output logic [WIDTH-1:0]     b_out,
  output logic                 b_valid,
  output logic                 step_up,
  output logic                 step_dn,
  output logic                 step_err,
  output logic [ERR_CNT_W-1:0] err_cnt,
  output logic                 primed
);

  state_t           r_state;
  logic [WIDTH-1:0] r_ref;
  logic [WIDTH-1:0] w_dec;
  logic [WIDTH-1:0] w_plus;
  logic [WIDTH-1:0] w_minus;

  gray_to_binary #(.WIDTH(WIDTH)) u_dec (
    .gray (g_in),
    .bin  (w_dec)
  );

  assign w_plus  = r_ref + WIDTH'(1);
  assign w_minus = r_ref - WIDTH'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_ref    <= '0;
      b_out    <= '0;
      b_valid  <= 1'b0;
      step_up  <= 1'b0;
      step_dn  <= 1'b0;
      step_err <= 1'b0;
      err_cnt  <= '0;
      primed   <= 1'b0;
    end else begin
      b_valid  <= 1'b0;
      step_up  <= 1'b0;
      step_dn  <= 1'b0;
      step_err <= 1'b0;
      if (clear) begin
        // The coincident sample is dropped; b_out keeps its last value.
        r_state <= ST_IDLE;
        r_ref   <= '0;
        err_cnt <= '0;
        primed  <= 1'b0;
      end else if (g_valid) begin
        b_out   <= w_dec;
        b_valid <= 1'b1;
        r_ref   <= w_dec;
        case (r_state)
          ST_IDLE: begin
            r_state <= ST_TRACK;
            primed  <= 1'b1;
          end
          ST_TRACK: begin
            // Up is tested before down so WIDTH=1 resolves to step_up.
            if (w_dec == r_ref) begin
              // unchanged position
            end else if (w_dec == w_plus) begin
              step_up <= 1'b1;
            end else if (w_dec == w_minus) begin
              step_dn <= 1'b1;
            end else begin
              step_err <= 1'b1;
              if (err_cnt != '1) err_cnt <= err_cnt + ERR_CNT_W'(1);
            end
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_gray_step_monitor.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_gray_step_monitor : table + scoreboard bench, two counter widths  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_gray_step_monitor;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       g_valid = 1'b0;
  logic       clear = 1'b0;
  logic [3:0] g_in = 4'h0;

  logic [3:0] b_out_a, b_out_b;
  logic       b_valid_a, b_valid_b, up_a, up_b, dn_a, dn_b, err_a, err_b, primed_a, primed_b;
  logic [7:0] cnt_a;
  logic [1:0] cnt_b;

  always #5 clk = ~clk;

  gray_step_monitor #(.WIDTH(4), .ERR_CNT_W(8)) dut_a (
    .clk(clk), .rst(rst), .g_valid(g_valid), .g_in(g_in), .clear(clear),
    .b_out(b_out_a), .b_valid(b_valid_a), .step_up(up_a), .step_dn(dn_a),
    .step_err(err_a), .err_cnt(cnt_a), .primed(primed_a)
  );

  gray_step_monitor #(.WIDTH(4), .ERR_CNT_W(2)) dut_b (
    .clk(clk), .rst(rst), .g_valid(g_valid), .g_in(g_in), .clear(clear),
    .b_out(b_out_b), .b_valid(b_valid_b), .step_up(up_b), .step_dn(dn_b),
    .step_err(err_b), .err_cnt(cnt_b), .primed(primed_b)
  );

  typedef enum logic [1:0] {C_NONE, C_UP, C_DN, C_ERR} cls_t;

  typedef struct {
    logic       v;
    logic [3:0] g;
    logic       clr;
    logic [3:0] b;
    cls_t       cls;
  } vec_t;

  typedef struct {
    logic [3:0] b;
    logic       bv, up, dn, er;
    logic [7:0] c8;
    logic [1:0] c2;
    logic       pr;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  logic [3:0] m_b  = 4'h0;
  logic [7:0] m_c8 = 8'h0;
  logic [1:0] m_c2 = 2'h0;
  logic       m_pr = 1'b0;

  function automatic logic [3:0] gray(input int i);
    logic [3:0] x;
    x = 4'(i);
    return x ^ (x >> 1);
  endfunction

  function automatic vec_t mk(input logic v, input logic [3:0] g, input logic clr,
                              input logic [3:0] b, input cls_t cls);
    vec_t r;
    r.v = v; r.g = g; r.clr = clr; r.b = b; r.cls = cls;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_chk++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, expv);
    end
  endtask

  task automatic check_outputs(input exp_t e);
    chk("b_out",    32'(b_out_a),   32'(e.b));
    chk("b_valid",  32'(b_valid_a), 32'(e.bv));
    chk("step_up",  32'(up_a),      32'(e.up));
    chk("step_dn",  32'(dn_a),      32'(e.dn));
    chk("step_err", 32'(err_a),     32'(e.er));
    chk("err_cnt",  32'(cnt_a),     32'(e.c8));
    chk("primed",   32'(primed_a),  32'(e.pr));
    chk("b_out_w2",   32'(b_out_b),   32'(e.b));
    chk("b_valid_w2", 32'(b_valid_b), 32'(e.bv));
    chk("steps_w2",   32'({up_b, dn_b, err_b}), 32'({e.up, e.dn, e.er}));
    chk("err_cnt_w2", 32'(cnt_b),     32'(e.c2));
    chk("primed_w2",  32'(primed_b),  32'(e.pr));
  endtask

  // Drive one vector, predict its result into the scoreboard, compare after the edge.
  task automatic apply(input vec_t vv);
    exp_t e;
    g_valid = vv.v;
    g_in    = vv.g;
    clear   = vv.clr;
    e.bv = 1'b0;
    if (vv.clr) begin
      m_pr = 1'b0; m_c8 = 8'h0; m_c2 = 2'h0;
    end else if (vv.v) begin
      e.bv = 1'b1;
      m_b  = vv.b;
      m_pr = 1'b1;
      if (vv.cls == C_ERR) begin
        if (m_c8 != 8'hFF) m_c8 = m_c8 + 8'h1;
        if (m_c2 != 2'h3)  m_c2 = m_c2 + 2'h1;
      end
    end
    e.up = e.bv && (vv.cls == C_UP);
    e.dn = e.bv && (vv.cls == C_DN);
    e.er = e.bv && (vv.cls == C_ERR);
    e.b  = m_b;
    e.c8 = m_c8;
    e.c2 = m_c2;
    e.pr = m_pr;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      n_chk++; n_fail++;
      $display("FAIL scoreboard_empty at %0t: got 0 entries expected 1", $time);
    end else begin
      check_outputs(sb.pop_front());
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    exp_t zero;
    zero = '{b: 4'h0, bv: 1'b0, up: 1'b0, dn: 1'b0, er: 1'b0, c8: 8'h0, c2: 2'h0, pr: 1'b0};

    // Count up 0..15 and wrap to 0; first sample only primes.
    vecs.push_back(mk(1'b1, gray(0), 1'b0, 4'd0, C_NONE));
    for (int i = 1; i <= 16; i++) vecs.push_back(mk(1'b1, gray(i % 16), 1'b0, 4'(i % 16), C_UP));
    vecs.push_back(mk(1'b0, 4'h0, 1'b0, 4'd0, C_NONE));
    vecs.push_back(mk(1'b1, 4'b0001, 1'b0, 4'd1,  C_UP));
    vecs.push_back(mk(1'b1, 4'b0011, 1'b0, 4'd2,  C_UP));
    vecs.push_back(mk(1'b1, 4'b0010, 1'b0, 4'd3,  C_UP));
    vecs.push_back(mk(1'b1, 4'b0010, 1'b0, 4'd3,  C_NONE));
    vecs.push_back(mk(1'b1, 4'b0011, 1'b0, 4'd2,  C_DN));
    vecs.push_back(mk(1'b1, 4'b0001, 1'b0, 4'd1,  C_DN));
    vecs.push_back(mk(1'b1, 4'b0000, 1'b0, 4'd0,  C_DN));
    vecs.push_back(mk(1'b1, 4'b1000, 1'b0, 4'd15, C_DN));
    // Plain clear, then 3 -> 12 illegal, 12 -> 13 up.
    vecs.push_back(mk(1'b0, 4'h0,    1'b1, 4'd15, C_NONE));
    vecs.push_back(mk(1'b1, 4'b0010, 1'b0, 4'd3,  C_NONE));
    vecs.push_back(mk(1'b1, 4'b1010, 1'b0, 4'd12, C_ERR));
    vecs.push_back(mk(1'b1, 4'b1011, 1'b0, 4'd13, C_UP));
    // Repeated illegal jumps: narrow counter saturates, wide one keeps counting.
    vecs.push_back(mk(1'b1, 4'b0111, 1'b0, 4'd5,  C_ERR));
    vecs.push_back(mk(1'b1, 4'b0000, 1'b0, 4'd0,  C_ERR));
    vecs.push_back(mk(1'b1, 4'b1101, 1'b0, 4'd9,  C_ERR));
    vecs.push_back(mk(1'b1, 4'b0011, 1'b0, 4'd2,  C_ERR));
    vecs.push_back(mk(1'b1, 4'b1010, 1'b0, 4'd12, C_ERR));
    vecs.push_back(mk(1'b1, 4'b0001, 1'b0, 4'd1,  C_ERR));
    // One-bit Gray change that is still an illegal binary jump (1 -> 14).
    vecs.push_back(mk(1'b1, 4'b1001, 1'b0, 4'd14, C_ERR));
    vecs.push_back(mk(1'b0, 4'h0,    1'b0, 4'd14, C_NONE));
    // Clear wins over a coincident sample; next sample only re-primes.
    vecs.push_back(mk(1'b1, 4'b0100, 1'b1, 4'd7,  C_NONE));
    vecs.push_back(mk(1'b1, 4'b1100, 1'b0, 4'd8,  C_NONE));
    vecs.push_back(mk(1'b1, 4'b0100, 1'b0, 4'd7,  C_DN));

    // Reset state.
    #12;
    check_outputs(zero);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Short stream, then asynchronous reset between clock edges.
    apply(mk(1'b1, gray(5), 1'b0, 4'd5, C_NONE));
    apply(mk(1'b1, gray(6), 1'b0, 4'd6, C_UP));
    g_valid = 1'b1;
    g_in    = gray(7);
    #2;
    rst = 1'b1;
    #1;
    check_outputs(zero);
    m_b = 4'h0; m_c8 = 8'h0; m_c2 = 2'h0; m_pr = 1'b0;
    g_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    foreach (vecs[i]) apply(vecs[i]);

    if (sb.size() != 0) begin
      n_chk++; n_fail++;
      $display("FAIL scoreboard_leftover: got %0d entries expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
